// File: rtl/m1_muldiv_ctrl_pkg.sv
// Shared opcode and state encodings for the M1 multiply/divide controller.
package m1_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5,
        MD_OP_MFHI  = 3'd6,
        MD_OP_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } md_state_e;

    localparam int ABP_TIMEOUT_DEFAULT = 64;

    function automatic logic is_mul(md_op_e op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

endpackage

// File: rtl/m1_abp_port.sv
// One ABP request/ack channel: toggling request level, ack compare and
// a wait-cycle counter that flags a missing ack.
module m1_abp_port #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic wait_en,
    input  logic ack,
    output logic req,
    output logic done,
    output logic timeout
);

    localparam int CW = (TIMEOUT >= 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // An ack only counts while the owner is actually waiting on this channel.
    assign done    = wait_en && (ack == req);
    // Fires on the edge where the count would reach TIMEOUT, i.e. after TIMEOUT wait cycles.
    assign timeout = (TIMEOUT != 0) && wait_en && !done && (count == CW'(TIMEOUT - 1));

    // Request toggles once per operation; the counter restarts on every new request.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            req   <= 1'b0;
            count <= '0;
        end else if (start) begin
            req   <= ~req;
            count <= '0;
        end else if (wait_en && !done && (TIMEOUT != 0)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/m1_muldiv_ctrl.sv
// M1 multiply/divide sequencer: accepts CPU commands, drives the multiplier
// and divider over ABP and owns the HI/LO registers.
//
// state     | meaning
// IDLE      | ready for a command, moves/reads of HI/LO complete here
// MUL_WAIT  | multiplier request outstanding
// DIV_WAIT  | divider request outstanding
// ERROR     | an ack never arrived; blocked until reset
module m1_muldiv_ctrl
    import m1_muldiv_ctrl_pkg::*;
#(
    parameter int ABP_TIMEOUT = ABP_TIMEOUT_DEFAULT
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic        cmd_ready_o,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_signed_o,
    output logic        mul_req_o,
    input  logic        mul_ack_i,
    input  logic [63:0] mul_product_i,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_signed_o,
    output logic        div_req_o,
    input  logic        div_ack_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);

    md_state_e state;
    md_op_e    op;
    logic      accept;
    logic      mul_start, mul_done, mul_timeout;
    logic      div_start, div_done, div_timeout;

    assign op        = md_op_e'(cmd_op_i);
    // cmd_ready_o is high exactly in IDLE, so it doubles as the accept qualifier.
    assign accept    = cmd_valid_i && cmd_ready_o;
    assign mul_start = accept && is_mul(op);
    assign div_start = accept && ((op == MD_OP_DIV) || (op == MD_OP_DIVU)) && (cmd_b_i != '0);

    m1_abp_port #(.TIMEOUT(ABP_TIMEOUT)) u_mul_port (
        .clk     (sys_clock_i),
        .rst_b   (sys_reset_i),
        .start   (mul_start),
        .wait_en (state == ST_MUL_WAIT),
        .ack     (mul_ack_i),
        .req     (mul_req_o),
        .done    (mul_done),
        .timeout (mul_timeout)
    );

    m1_abp_port #(.TIMEOUT(ABP_TIMEOUT)) u_div_port (
        .clk     (sys_clock_i),
        .rst_b   (sys_reset_i),
        .start   (div_start),
        .wait_en (state == ST_DIV_WAIT),
        .ack     (div_ack_i),
        .req     (div_req_o),
        .done    (div_done),
        .timeout (div_timeout)
    );

    // Controller FSM with all CPU-facing and operand outputs registered.
    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_i) begin
            state        <= ST_IDLE;
            cmd_ready_o  <= 1'b1;
            res_valid_o  <= 1'b0;
            res_data_o   <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
            err_o        <= 1'b0;
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            mul_signed_o <= 1'b0;
            div_a_o      <= '0;
            div_b_o      <= '0;
            div_signed_o <= 1'b0;
        end else begin
            res_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            MD_OP_MULT, MD_OP_MULTU: begin
                                mul_a_o      <= cmd_a_i;
                                mul_b_o      <= cmd_b_i;
                                mul_signed_o <= (op == MD_OP_MULT);
                                state        <= ST_MUL_WAIT;
                                cmd_ready_o  <= 1'b0;
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                if (cmd_b_i != '0) begin
                                    div_a_o      <= cmd_a_i;
                                    div_b_o      <= cmd_b_i;
                                    div_signed_o <= (op == MD_OP_DIV);
                                    state        <= ST_DIV_WAIT;
                                    cmd_ready_o  <= 1'b0;
                                end else begin
                                    // Divide by zero never reaches the divider.
                                    lo_o <= 32'hFFFF_FFFF;
                                    hi_o <= cmd_a_i;
                                end
                            end
                            MD_OP_MTHI: hi_o <= cmd_a_i;
                            MD_OP_MTLO: lo_o <= cmd_a_i;
                            MD_OP_MFHI: begin
                                res_data_o  <= hi_o;
                                res_valid_o <= 1'b1;
                            end
                            MD_OP_MFLO: begin
                                res_data_o  <= lo_o;
                                res_valid_o <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL_WAIT: begin
                    if (mul_done) begin
                        {hi_o, lo_o} <= mul_product_i;
                        state        <= ST_IDLE;
                        cmd_ready_o  <= 1'b1;
                    end else if (mul_timeout) begin
                        err_o <= 1'b1;
                        state <= ST_ERROR;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_done) begin
                        lo_o        <= div_quotient_i;
                        hi_o        <= div_remainder_i;
                        state       <= ST_IDLE;
                        cmd_ready_o <= 1'b1;
                    end else if (div_timeout) begin
                        err_o <= 1'b1;
                        state <= ST_ERROR;
                    end
                end
                default: begin
                    cmd_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m1_muldiv_ctrl.sv
// Bench for m1_muldiv_ctrl: behavioural multiplier/divider on the ABP side,
// HI/LO reference model, and a scoreboard for MFHI/MFLO results.
module tb_m1_muldiv_ctrl;
    import m1_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic        cmd_ready, res_valid, err;
    logic [31:0] res_data, hi, lo;
    logic [31:0] mul_a, mul_b, div_a, div_b;
    logic        mul_signed, mul_req, mul_ack, div_signed, div_req, div_ack;
    logic [63:0] mul_product;
    logic [31:0] div_q, div_r;

    int          checks = 0;
    int          errors = 0;
    int          res_count = 0;
    logic [31:0] res_q[$];
    logic [31:0] exp_res;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          mul_lat = 2, div_lat = 3;
    bit          div_hang = 1'b0;

    always #5 clk = ~clk;

    m1_muldiv_ctrl dut (
        .sys_clock_i(clk), .sys_reset_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .cmd_ready_o(cmd_ready), .res_valid_o(res_valid), .res_data_o(res_data),
        .hi_o(hi), .lo_o(lo), .err_o(err),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_signed_o(mul_signed),
        .mul_req_o(mul_req), .mul_ack_i(mul_ack), .mul_product_i(mul_product),
        .div_a_o(div_a), .div_b_o(div_b), .div_signed_o(div_signed),
        .div_req_o(div_req), .div_ack_i(div_ack),
        .div_quotient_i(div_q), .div_remainder_i(div_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: acks mul_lat cycles after seeing a new request level.
    initial begin : mul_unit
        int cnt;
        logic signed [63:0] sa, sb;
        cnt = 0; mul_ack = 1'b0; mul_product = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mul_ack = 1'b0; cnt = 0;
            end else if (mul_req !== mul_ack) begin
                if (cnt >= mul_lat) begin
                    sa = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
                    sb = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
                    mul_product = sa * sb;
                    mul_ack = mul_req; cnt = 0;
                end else cnt++;
            end
        end
    end

    // Behavioural divider, with a mode that never acknowledges.
    initial begin : div_unit
        int cnt;
        int sa, sb;
        cnt = 0; div_ack = 1'b0; div_q = '0; div_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                div_ack = 1'b0; cnt = 0;
            end else if (div_req !== div_ack && !div_hang) begin
                if (cnt >= div_lat) begin
                    if (div_signed) begin
                        sa = div_a; sb = div_b;
                        div_q = sa / sb; div_r = sa % sb;
                    end else begin
                        div_q = div_a / div_b; div_r = div_a % div_b;
                    end
                    div_ack = div_req; cnt = 0;
                end else cnt++;
            end
        end
    end

    // Result monitor: every res_valid pulse must match the oldest expected read.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                res_count++;
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL res_unexpected: got data %h expected no result", res_data);
                end else begin
                    exp_res = res_q.pop_front();
                    chk("res_data", {32'b0, res_data}, {32'b0, exp_res});
                end
            end
        end
    end

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b, output int waited);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; waited = 0;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got ready %b expected 1 for op %0d", cmd_ready, op);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Reference model updated from the instruction semantics, then the command is issued.
    task automatic do_cmd(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, w;
        logic [63:0] p;
        sa = a; sb = b;
        case (op)
            MD_OP_MULT:  begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; end
            MD_OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            MD_OP_DIV:   if (b == 0) begin m_lo = '1; m_hi = a; end
                         else begin m_lo = sa / sb; m_hi = sa % sb; end
            MD_OP_DIVU:  if (b == 0) begin m_lo = '1; m_hi = a; end
                         else begin m_lo = a / b; m_hi = a % b; end
            MD_OP_MTHI:  m_hi = a;
            MD_OP_MTLO:  m_lo = a;
            MD_OP_MFHI:  res_q.push_back(m_hi);
            MD_OP_MFLO:  res_q.push_back(m_lo);
            default: ;
        endcase
        issue(op, a, b, w);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got ready %b expected 1", cmd_ready);
        end
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int w, rc;
        logic dreq;
        md_op_e rop;
        logic [31:0] ra, rb;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_res", {31'b0, res_valid, res_data}, 0);
        chk("rst_err_req", {err, mul_req, div_req, mul_signed, div_signed}, 0);
        chk("rst_operands", {mul_a | mul_b, div_a | div_b}, 0);
        rst_n = 1'b1;

        // MULTU 17*3
        mul_lat = 4;
        do_cmd(MD_OP_MULTU, 32'd17, 32'd3);
        chk("multu_req", mul_req, 1);
        chk("multu_busy", cmd_ready, 0);
        chk("multu_opnd", {mul_a, mul_b}, {32'd17, 32'd3});
        wait_idle();
        chk("multu_hilo", {hi, lo}, {32'd0, 32'd51});

        // MULT -7*3, then MFLO
        do_cmd(MD_OP_MULT, 32'hFFFF_FFF9, 32'd3);
        wait_idle();
        chk("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        rc = res_count;
        do_cmd(MD_OP_MFLO, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mflo_pulse_drop", res_valid, 0);
        chk("mflo_pulse_count", rc + 1, res_count);

        // DIVU 17/5 then DIV by zero
        do_cmd(MD_OP_DIVU, 32'd17, 32'd5);
        wait_idle();
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd3});
        dreq = div_req;
        do_cmd(MD_OP_DIV, 32'd9, 32'd0);
        @(negedge clk);
        chk("div0_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        chk("div0_req", div_req, dreq);
        chk("div0_ready", cmd_ready, 1);

        // MTHI / MFHI
        do_cmd(MD_OP_MTHI, 32'h1234, 0);
        do_cmd(MD_OP_MFHI, 0, 0);
        repeat (2) @(negedge clk);

        // MTLO held during MUL_WAIT
        mul_lat = 6;
        do_cmd(MD_OP_MULTU, 32'd5, 32'd7);
        m_lo = 32'hABCD;
        issue(MD_OP_MTLO, 32'hABCD, 0, w);
        chk("mtlo_held", {31'b0, w > 3}, 1);
        chk("mtlo_after_ack", mul_ack, mul_req);
        @(negedge clk);
        chk("mtlo_hilo", {hi, lo}, {32'd0, 32'hABCD});

        // Randomised command stream against the model
        for (int i = 0; i < 60; i++) begin
            rop = md_op_e'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 100);
            if (ra == 32'h8000_0000) ra = 32'd1;
            mul_lat = $urandom_range(0, 5);
            div_lat = $urandom_range(0, 5);
            do_cmd(rop, ra, rb);
        end
        wait_idle();
        do_cmd(MD_OP_MFHI, 0, 0);
        do_cmd(MD_OP_MFLO, 0, 0);
        repeat (3) @(negedge clk);
        chk("rand_hilo", {hi, lo}, {m_hi, m_lo});

        // Divider never acks: timeout after 64 wait cycles
        div_hang = 1'b1;
        issue(MD_OP_DIVU, 32'd100, 32'd7, w);
        repeat (63) @(posedge clk);
        #1 chk("timeout_early", err, 0);
        @(posedge clk);
        #1 chk("timeout_err", err, 1);
        chk("timeout_hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = MD_OP_MTHI; cmd_a = 32'h5555;
        repeat (5) @(negedge clk);
        chk("error_blocks", {cmd_ready, err}, 2'b01);
        chk("error_hi", hi, m_hi);
        cmd_valid = 1'b0;

        rst_n = 1'b0; div_hang = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        chk("err_reset", {err, div_req, cmd_ready}, 3'b001);

        // Reset while the multiplier is outstanding
        mul_lat = 50;
        issue(MD_OP_MULT, 32'd3, 32'd4, w);
        repeat (5) @(negedge clk);
        chk("midmul_pending", {mul_req, cmd_ready}, 2'b10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midmul_reset", {mul_req, cmd_ready, err}, 3'b010);
        chk("midmul_hilo", {hi, lo}, 0);
        rst_n = 1'b1;
        mul_lat = 1;
        do_cmd(MD_OP_MULTU, 32'd6, 32'd7);
        wait_idle();
        chk("post_reset_mul", {hi, lo}, {32'd0, 32'd42});

        repeat (3) @(negedge clk);
        chk("res_queue_empty", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
